pulse_width_mc: RTL
===================

# pulse_width_mc

Multi-channel, parametrised RC-receiver pulse-width capture unit for the auto/manual CPLD. It measures the high time of CH independent PWM inputs in prescaled ticks and publishes per-channel widths with valid, new-sample and signal-lost flags. Every capture is range-checked, so out-of-range pulses never reach the width registers. The mode-select and mixing logic reads its outputs to decide between autopilot and manual control.

## Interface
- CH, default 4: number of input channels.
- CNT_W, default 12: width counter and result width, in bits.
- PRESC, default 1: clocks per measurement tick, at least 1.
- MIN_W, default 2: smallest accepted width, in ticks.
- MAX_W, default 2000: largest accepted width, in ticks; must be below 2^CNT_W - 1.
- TIMEOUT, default 4000: number of ticks without an accepted pulse before the channel is flagged lost.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  capture enable.
- PulIn  in  CH  asynchronous PWM inputs.
- width  out  CH*CNT_W  last accepted width; channel k occupies bits [k*CNT_W +: CNT_W].
- valid  out  CH  channel holds an accepted width and is not lost.
- new_stb  out  CH  one-clock strobe when a new width has been accepted.
- err_stb  out  CH  one-clock strobe when a pulse has been rejected.
- lost  out  CH  timeout flag.

## Operation
- Each input passes through a 2-flop synchroniser and then an edge-detect register. s is the synchronised level and p is its previous value.
- A single free-running prescaler generates tick, a 1-clock pulse every PRESC clocks. With PRESC=1, tick is held high.
- Each channel has its own FSM:
  - WAIT_LOW: reset and enable-entry state, so a partial pulse is never measured. Leave for WAIT_RISE when s=0.
  - WAIT_RISE: on a rising edge (p=0, s=1), load cnt with tick?1:0 and go to HIGH.
  - HIGH, while s=1: cnt accumulates cnt+tick. If cnt would exceed MAX_W, pulse err_stb and go to WAIT_LOW.
  - HIGH, on a falling edge: if MIN_W ≤ cnt ≤ MAX_W, load width with cnt, pulse new_stb, set valid, clear lost, and clear the period counter. Otherwise pulse err_stb and leave width unchanged. Either way, go to WAIT_RISE.
- Each channel's period counter increments on tick and saturates at TIMEOUT. When it reaches TIMEOUT, valid clears and lost sets; lost stays set until the next accepted pulse.
- en=0:
  - All FSMs are forced to WAIT_LOW.
  - cnt and the period counters clear.
  - Strobes stay 0 and valid clears.
  - width and lost hold their values.
  - When en returns to 1, every channel restarts from WAIT_LOW.
- Channels are fully independent, and simultaneous edges on any set of channels are handled in the same cycle.
- Arithmetic is unsigned. cnt is CNT_W bits and never wraps, because the overflow check fires first.

## Timing
- Reset values: width=0, valid=0, new_stb=0, err_stb=0, lost=0. Synchronisers, counters and the prescaler all clear, and every FSM is in WAIT_LOW.
- Reset asserted mid-pulse returns everything to the reset values immediately. That pulse is discarded, because the FSM must then see s=0 first.
- Latency: new_stb and width update on the 3rd rising clk after the first edge at which PulIn is sampled low (2 synchroniser stages plus 1 capture register). Rising-edge latency is the same, so the measured width equals the true high time ±1 tick.
- The strobes are exactly 1 clock wide. new_stb and err_stb are never both high on the same channel in the same cycle.
- A falling edge and the timeout threshold arriving in the same cycle: the accept wins, so valid=1 and lost=0.
- Minimum measurable low time between pulses is 1 clock, since WAIT_RISE is entered directly after a falling edge.
- Overflow is flagged in the cycle cnt would reach MAX_W+1, not at the later falling edge.

## Test plan
Bench settings unless noted: CH=4, CNT_W=12, PRESC=1, MIN_W=2, MAX_W=2000, TIMEOUT=4000.
- Reset and basic capture: hold PulIn[0] high for 1500 clocks, then low. Required: width[0]=1500, valid[0]=1, and new_stb[0] for 1 clock, 3 clocks after the fall. All outputs read 0 before the first pulse.
- Prescale and simultaneous edges: with PRESC=50, drive all 4 channels with the same 1000-clock pulse. Required: all widths read 20 (±1), and the 4 new_stb pulses occur in the same cycle.
- Range rejection:
  - A 1-clock pulse gives err_stb with width unchanged.
  - A 2500-clock pulse gives err_stb at clock 2001 of the high time, no new_stb at the fall, and width holding its previous value.
- Timeout: after one accepted pulse, hold the input low for 4000 clocks. Required: valid=0 and lost=1. The next accepted 1200-clock pulse gives lost=0, valid=1 and width=1200.
- Enable and partial pulses:
  - Drop en mid-pulse: no strobe, valid=0, width holds.
  - Raise en while PulIn is high: that pulse is ignored, and the following pulse is measured correctly.
- Reset mid-pulse: assert rst_n=0 during a 1000-clock pulse. Required: outputs return to 0 immediately, and no capture occurs until after the next complete low-to-high transition.

Source files
------------

// File: rtl/pulse_width_mc.sv
// Multi-channel RC pulse-width capture: measures the high time of each PWM input in
// prescaled ticks and publishes range-checked widths with valid/new/error/lost flags.
module pulse_width_mc #(
    parameter int CH      = 4,
    parameter int CNT_W   = 12,
    parameter int PRESC   = 1,
    parameter int MIN_W   = 2,
    parameter int MAX_W   = 2000,
    parameter int TIMEOUT = 4000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [CH-1:0]       PulIn,
    output logic [CH*CNT_W-1:0] width,
    output logic [CH-1:0]       valid,
    output logic [CH-1:0]       new_stb,
    output logic [CH-1:0]       err_stb,
    output logic [CH-1:0]       lost
);

    localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int PER_W = $clog2(TIMEOUT + 1);

    localparam logic [PW-1:0]    PRESC_TOP = PW'(PRESC - 1);
    localparam logic [PER_W-1:0] PER_MAX   = PER_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_W);
    localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_W);
    localparam logic [CNT_W:0]   MAX_X     = (CNT_W + 1)'(MAX_W);

    typedef enum logic [1:0] {
        WAIT_LOW,
        WAIT_RISE,
        HIGH
    } state_e;

    logic [CH-1:0] sync1_q, sync2_q, prev_q;
    logic [PW-1:0] presc_q;
    logic [1:0]    warm_q;
    logic          tick;
    logic          primed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= PulIn;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (presc_q == PRESC_TOP) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    assign tick = (presc_q == PRESC_TOP);

    // The cleared synchroniser reads as a false low just after reset; hold the FSMs
    // in WAIT_LOW until the pipeline carries real samples so a live pulse is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_q <= '0;
        end else if (warm_q != 2'd3) begin
            warm_q <= warm_q + 2'd1;
        end
    end

    assign primed = (warm_q == 2'd3);

    for (genvar k = 0; k < CH; k++) begin : g_ch
        state_e             state_q, state_d;
        logic [CNT_W-1:0]   cnt_q, cnt_d;
        logic [CNT_W-1:0]   width_q, width_d;
        logic [PER_W-1:0]   per_q, per_d;
        logic               valid_q, valid_d;
        logic               lost_q, lost_d;
        logic               new_q, new_d;
        logic               err_q, err_d;
        logic               s, p;
        logic [CNT_W:0]     cntNext;
        logic               ovf;

        assign s       = sync2_q[k];
        assign p       = prev_q[k];
        assign cntNext = {1'b0, cnt_q} + {{CNT_W{1'b0}}, tick};
        assign ovf     = (cntNext > MAX_X);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= WAIT_LOW;
                cnt_q   <= '0;
                width_q <= '0;
                per_q   <= '0;
                valid_q <= 1'b0;
                lost_q  <= 1'b0;
                new_q   <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                width_q <= width_d;
                per_q   <= per_d;
                valid_q <= valid_d;
                lost_q  <= lost_d;
                new_q   <= new_d;
                err_q   <= err_d;
            end
        end

        always_comb begin
            state_d = state_q;
            if (!en) begin
                state_d = WAIT_LOW;
            end else begin
                case (state_q)
                    WAIT_LOW:  if (primed && !s) state_d = WAIT_RISE;
                    WAIT_RISE: if (!p && s)      state_d = HIGH;
                    HIGH: begin
                        if (!s)       state_d = WAIT_RISE;
                        else if (ovf) state_d = WAIT_LOW;
                    end
                    default:          state_d = WAIT_LOW;
                endcase
            end
        end

        // Accept takes priority over a timeout reached in the same cycle.
        always_comb begin
            cnt_d   = cnt_q;
            width_d = width_q;
            per_d   = per_q;
            valid_d = valid_q;
            lost_d  = lost_q;
            new_d   = 1'b0;
            err_d   = 1'b0;
            if (!en) begin
                cnt_d   = '0;
                per_d   = '0;
                valid_d = 1'b0;
            end else begin
                if (tick && (per_q != PER_MAX)) per_d = per_q + PER_W'(1);
                case (state_q)
                    WAIT_RISE: begin
                        if (!p && s) cnt_d = {{(CNT_W-1){1'b0}}, tick};
                    end
                    HIGH: begin
                        if (s) begin
                            if (ovf) begin
                                err_d = 1'b1;
                                cnt_d = '0;
                            end else begin
                                cnt_d = cntNext[CNT_W-1:0];
                            end
                        end else if ((cnt_q >= MIN_C) && (cnt_q <= MAX_C)) begin
                            width_d = cnt_q;
                            new_d   = 1'b1;
                            valid_d = 1'b1;
                            lost_d  = 1'b0;
                            per_d   = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
                if ((per_q == PER_MAX) && !new_d) begin
                    valid_d = 1'b0;
                    lost_d  = 1'b1;
                end
            end
        end

        assign width[k*CNT_W +: CNT_W] = width_q;
        assign valid[k]   = valid_q;
        assign lost[k]    = lost_q;
        assign new_stb[k] = new_q;
        assign err_stb[k] = err_q;
    end

endmodule
